// File: rtl/pk_cache_pkg.sv
// Shared types and constants for the public-key cache scheduler.
package pk_cache_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    READY,
    READ,
    DONE
  } state_t;

  localparam logic [1:0] MODE_WR   = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [2:0] K_MIN = 3'd3;
  localparam logic [2:0] K_MAX = 3'd4;

  function automatic logic k_legal(input logic [2:0] k);
    return (k >= K_MIN) && (k <= K_MAX);
  endfunction

endpackage

// File: rtl/pk_cache_sched_if.sv
// Loader, encryption-core and cache signals of the key cache scheduler.
interface pk_cache_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COLS   = 4
);
  localparam int ROW_W = NUM_COLS * DATA_WIDTH;

  logic             load_valid;
  logic             load_ready;
  logic [ROW_W-1:0] load_row;
  logic [15:0]      load_sum;
  logic             key_invalidate;
  logic             enc_start;
  logic [2:0]       enc_k;
  logic             enc_row_valid;
  logic [ROW_W-1:0] enc_row;
  logic [15:0]      enc_sum;
  logic             enc_done;
  logic             enc_error;
  logic             key_loaded;
  logic             cache_clr;
  logic [1:0]       cache_mode;
  logic [2:0]       cache_kyber_k;
  logic             cache_encryption_req;
  logic [ROW_W-1:0] cache_row_in;
  logic [15:0]      cache_sum_in;
  logic [ROW_W-1:0] cache_row_out;
  logic [15:0]      cache_sum_out;
  logic             cache_full;

  modport master (
    input  load_valid, load_row, load_sum, key_invalidate, enc_start, enc_k,
           cache_row_out, cache_sum_out, cache_full,
    output load_ready, enc_row_valid, enc_row, enc_sum, enc_done, enc_error,
           key_loaded, cache_clr, cache_mode, cache_kyber_k,
           cache_encryption_req, cache_row_in, cache_sum_in
  );

  modport slave (
    output load_valid, load_row, load_sum, key_invalidate, enc_start, enc_k,
           cache_row_out, cache_sum_out, cache_full,
    input  load_ready, enc_row_valid, enc_row, enc_sum, enc_done, enc_error,
           key_loaded, cache_clr, cache_mode, cache_kyber_k,
           cache_encryption_req, cache_row_in, cache_sum_in
  );

endinterface

// File: rtl/pk_rd_pipe.sv
// Aligns cache read data with a one-cycle valid and masks the unused column for k=3.
module pk_rd_pipe
  import pk_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COLS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_issue,
  input  logic [2:0]                     kyber_k,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] row_in,
  input  logic [15:0]                    sum_in,
  output logic                           row_valid,
  output logic [NUM_COLS*DATA_WIDTH-1:0] row_out,
  output logic [15:0]                    sum_out
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;

  logic [ROW_W-1:0] row_masked;

  always_comb begin
    row_masked = row_in;
    if (kyber_k == K_MIN) row_masked[ROW_W-1 -: DATA_WIDTH] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= 1'b0;
      row_out   <= '0;
      sum_out   <= '0;
    end else begin
      row_valid <= rd_issue;
      if (rd_issue) begin
        row_out <= row_masked;
        sum_out <= sum_in;
      end
    end
  end

endmodule

// File: rtl/pk_cache_sched.sv
// Sequences key loading into the row cache and single-use read passes to the encryption core.
//
// state | meaning
// CLEAR | one-cycle cache clear, counters rewound
// LOAD  | accepting NUM_ROWS rows, then waiting on cache_full
// READY | complete key held, waiting for enc_start
// READ  | issuing NUM_ROWS consecutive cache reads
// DONE  | last row valid, enc_done pulse; key consumed
module pk_cache_sched
  import pk_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  pk_cache_sched_if.master  bus
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam logic [CNT_W-1:0] ROWS_C  = CNT_W'(NUM_ROWS);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NUM_ROWS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]       k_q, k_d;
  logic             enc_error_q, enc_error_d;

  logic             load_ready;
  logic             wr_fire;
  logic             rd_issue;
  logic             start_ok;
  logic             clr;
  logic             key_loaded;
  logic             done;
  logic [1:0]       mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      k_q         <= K_MIN;
      enc_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      k_q         <= k_d;
      enc_error_q <= enc_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    k_d        = k_q;
    load_ready = 1'b0;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    start_ok   = 1'b0;
    clr        = 1'b0;
    key_loaded = 1'b0;
    done       = 1'b0;
    mode       = MODE_HOLD;

    case (state_q)
      CLEAR: begin
        clr      = 1'b1;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        load_ready = (wr_cnt_q < ROWS_C);
        wr_fire    = load_ready && bus.load_valid;
        if (wr_fire) begin
          mode     = MODE_WR;
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if ((wr_cnt_q == ROWS_C) && bus.cache_full) state_d = READY;
      end
      READY: begin
        key_loaded = 1'b1;
        if (bus.enc_start && k_legal(bus.enc_k)) begin
          start_ok = 1'b1;
          k_d      = bus.enc_k;
          rd_cnt_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        key_loaded = 1'b1;
        mode       = MODE_RD;
        rd_issue   = 1'b1;
        if (rd_cnt_q < ROWS_C) rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_RD) state_d = DONE;
      end
      DONE: begin
        key_loaded = 1'b1;
        done       = 1'b1;
        state_d    = CLEAR;
      end
      default: state_d = CLEAR;
    endcase

    // An invalidated key must not be read any further, nor start a new pass.
    if (bus.key_invalidate && (state_q != CLEAR)) begin
      state_d  = CLEAR;
      start_ok = 1'b0;
      rd_issue = 1'b0;
      k_d      = k_q;
    end

    enc_error_d = bus.enc_start && !start_ok;
  end

  pk_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_COLS   (NUM_COLS)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (rd_issue),
    .kyber_k   (k_q),
    .row_in    (bus.cache_row_out),
    .sum_in    (bus.cache_sum_out),
    .row_valid (bus.enc_row_valid),
    .row_out   (bus.enc_row),
    .sum_out   (bus.enc_sum)
  );

  // Gate with rst so the clear pulse belongs to the first cycle after release only.
  assign bus.cache_clr            = clr && !rst;
  assign bus.load_ready           = load_ready;
  assign bus.key_loaded           = key_loaded;
  assign bus.enc_done             = done;
  assign bus.enc_error            = enc_error_q;
  assign bus.cache_mode           = mode;
  assign bus.cache_kyber_k        = k_q;
  assign bus.cache_encryption_req = rd_issue;
  assign bus.cache_row_in         = bus.load_row;
  assign bus.cache_sum_in         = bus.load_sum;

endmodule

// File: tb/tb_pk_cache_sched.sv
// Directed bench for pk_cache_sched: reset, key load, k=4/k=3 passes, rejects and abort.
module tb_pk_cache_sched;
  import pk_cache_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int NC = 4;
  localparam int RW = NC * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pk_cache_sched_if #(.DATA_WIDTH(DW), .NUM_COLS(NC)) bus();

  pk_cache_sched #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rd_ptr   = 0;
  int wr_cycles = 0;

  function automatic logic [RW-1:0] row_pat(input int i);
    return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
  endfunction

  function automatic logic [15:0] sum_pat(input int i);
    return 16'h5000 + 16'(i);
  endfunction

  // Simple cache model: combinational read data, pointer advanced per read.
  always @(posedge clk) begin
    if (bus.cache_clr) rd_ptr <= 0;
    else if (bus.cache_encryption_req) rd_ptr <= rd_ptr + 1;
  end
  assign bus.cache_row_out = row_pat(rd_ptr);
  assign bus.cache_sum_out = sum_pat(rd_ptr);

  always @(posedge clk) begin
    if (!rst && bus.cache_mode == MODE_WR) wr_cycles <= wr_cycles + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input bit with_gap);
    int w0;
    w0 = wr_cycles;
    bus.cache_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bus.load_valid = 1'b1;
      bus.load_row   = row_pat(i);
      bus.load_sum   = sum_pat(i);
      #1;
      chk1("load_ready", bus.load_ready, 1'b1);
      chkw("mode_wr", 64'(bus.cache_mode), 64'(MODE_WR));
      chkw("row_in", bus.cache_row_in, row_pat(i));
      chkw("sum_in", 64'(bus.cache_sum_in), 64'(sum_pat(i)));
      @(negedge clk);
      if (with_gap && i == 3) begin
        bus.load_valid = 1'b0;
        #1;
        chkw("mode_gap", 64'(bus.cache_mode), 64'(MODE_HOLD));
        @(negedge clk);
      end
    end
    bus.load_valid = 1'b1;
    #1;
    chk1("wait_full_ready", bus.load_ready, 1'b0);
    chkw("wait_full_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));
    chk1("wait_full_loaded", bus.key_loaded, 1'b0);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.cache_full = 1'b1;
    #1;
    chk1("full_same_cycle", bus.key_loaded, 1'b0);
    @(negedge clk);
    #1;
    chk1("key_loaded", bus.key_loaded, 1'b1);
    chk1("ready_load_ready", bus.load_ready, 1'b0);
    chkw("ready_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));
    chkw("wr_cycles", 64'(wr_cycles - w0), 64'(NR));
  endtask

  task automatic run_pass(input logic [2:0] k);
    logic [RW-1:0] exp_row;
    bus.enc_start = 1'b1;
    bus.enc_k     = k;
    @(negedge clk);
    bus.enc_start = 1'b0;
    #1;
    chkw("r1_mode", 64'(bus.cache_mode), 64'(MODE_RD));
    chk1("r1_req", bus.cache_encryption_req, 1'b1);
    chk1("r1_valid", bus.enc_row_valid, 1'b0);
    chkw("r1_k", 64'(bus.cache_kyber_k), 64'(k));
    for (int j = 0; j < NR; j++) begin
      @(negedge clk);
      #1;
      exp_row = row_pat(j);
      if (k == 3'd3) exp_row[RW-1 -: DW] = '0;
      chk1("pass_valid", bus.enc_row_valid, 1'b1);
      chkw("pass_row", bus.enc_row, exp_row);
      chkw("pass_sum", 64'(bus.enc_sum), 64'(sum_pat(j)));
      chk1("pass_done", bus.enc_done, (j == NR - 1));
    end
    @(negedge clk);
    #1;
    chk1("post_clr", bus.cache_clr, 1'b1);
    chk1("post_valid", bus.enc_row_valid, 1'b0);
    chk1("post_done", bus.enc_done, 1'b0);
    chk1("post_loaded", bus.key_loaded, 1'b0);
    bus.cache_full = 1'b0;
  endtask

  initial begin
    bus.load_valid     = 1'b0;
    bus.load_row       = '0;
    bus.load_sum       = '0;
    bus.key_invalidate = 1'b0;
    bus.enc_start      = 1'b0;
    bus.enc_k          = 3'd0;
    bus.cache_full     = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk1("rst_clr", bus.cache_clr, 1'b0);
    chkw("rst_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));
    chkw("rst_k", 64'(bus.cache_kyber_k), 64'(3'd3));
    chk1("rst_load_ready", bus.load_ready, 1'b0);
    chk1("rst_key_loaded", bus.key_loaded, 1'b0);
    chk1("rst_valid", bus.enc_row_valid, 1'b0);
    chk1("rst_done", bus.enc_done, 1'b0);
    chk1("rst_error", bus.enc_error, 1'b0);
    chk1("rst_req", bus.cache_encryption_req, 1'b0);

    rst = 1'b0;
    #1;
    chk1("rel_clr", bus.cache_clr, 1'b1);
    chk1("rel_load_ready", bus.load_ready, 1'b0);
    chkw("rel_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));
    @(negedge clk);
    #1;
    chk1("load_clr_low", bus.cache_clr, 1'b0);
    chk1("load_ready_up", bus.load_ready, 1'b1);
    chkw("load_idle_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));

    load_key(1'b1);
    run_pass(3'd4);

    // enc_start while loading is rejected
    @(negedge clk);
    bus.enc_start = 1'b1;
    bus.enc_k     = 3'd4;
    @(negedge clk);
    bus.enc_start = 1'b0;
    #1;
    chk1("load_start_err", bus.enc_error, 1'b1);
    chk1("load_start_ready", bus.load_ready, 1'b1);
    chk1("load_start_loaded", bus.key_loaded, 1'b0);
    @(negedge clk);
    #1;
    chk1("load_err_drop", bus.enc_error, 1'b0);

    load_key(1'b0);

    // illegal k in READY
    bus.enc_start = 1'b1;
    bus.enc_k     = 3'd5;
    @(negedge clk);
    bus.enc_start = 1'b0;
    #1;
    chk1("k5_err", bus.enc_error, 1'b1);
    chk1("k5_loaded", bus.key_loaded, 1'b1);
    chkw("k5_mode", 64'(bus.cache_mode), 64'(MODE_HOLD));
    chk1("k5_req", bus.cache_encryption_req, 1'b0);
    chkw("k5_k_kept", 64'(bus.cache_kyber_k), 64'(3'd4));
    @(negedge clk);
    #1;
    chk1("k5_err_drop", bus.enc_error, 1'b0);
    chk1("k5_still_ready", bus.key_loaded, 1'b1);

    run_pass(3'd3);

    @(negedge clk);
    load_key(1'b0);

    // abort a k=4 pass on its 4th read cycle
    bus.enc_start = 1'b1;
    bus.enc_k     = 3'd4;
    @(negedge clk);
    bus.enc_start = 1'b0;
    #1;
    chk1("ab_r1_req", bus.cache_encryption_req, 1'b1);
    @(negedge clk);
    #1;
    chkw("ab_r2_row", bus.enc_row, row_pat(0));
    @(negedge clk);
    #1;
    chkw("ab_r3_row", bus.enc_row, row_pat(1));
    @(negedge clk);
    bus.key_invalidate = 1'b1;
    #1;
    chk1("ab_r4_valid", bus.enc_row_valid, 1'b1);
    chkw("ab_r4_row", bus.enc_row, row_pat(2));
    chk1("ab_r4_done", bus.enc_done, 1'b0);
    @(negedge clk);
    bus.key_invalidate = 1'b0;
    #1;
    chk1("ab_clr", bus.cache_clr, 1'b1);
    chk1("ab_valid", bus.enc_row_valid, 1'b0);
    chk1("ab_done", bus.enc_done, 1'b0);
    chk1("ab_loaded", bus.key_loaded, 1'b0);
    @(negedge clk);
    #1;
    chk1("ab_load_ready", bus.load_ready, 1'b1);
    chk1("ab_valid2", bus.enc_row_valid, 1'b0);
    chk1("ab_done2", bus.enc_done, 1'b0);
    chk1("ab_loaded2", bus.key_loaded, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
